// File: rtl/simple_pkg.sv
// Shared definitions for the run-control / program-load sequencer.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package simple_pkg;

    // Sequencer state encoding, also shown on the board display
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DAT_HI = 3'd3;
    localparam logic [2:0] ST_DAT_LO = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_PAUSE  = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    // Default instruction memory address width (4096 words)
    localparam int IMEM_AW_DEF = 12;

    // Processor no-operation encoding; also the idle value of the write-data bus
    localparam logic [15:0] NOP = 16'h0000;

    // True while the sequencer is consuming the program byte stream
    function automatic logic is_load_state(input logic [2:0] s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DAT_HI) || (s == ST_DAT_LO);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Byte-stream, instruction-memory write and processor control bundle.
// Latency: none (wires only).
// Backpressure: rx_valid/rx_ready handshake; memory and processor side never stall.
interface cpu_sequencer_if import simple_pkg::*; #(
    parameter int IMEM_AW = IMEM_AW_DEF
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [15:0]        imem_data;
    logic               cpu_halting;
    logic               cpu_reset;
    logic               cpu_clk_en;

    // Sequencer side
    modport master (
        input  rx_data, rx_valid, cpu_halting,
        output rx_ready, imem_we, imem_addr, imem_data, cpu_reset, cpu_clk_en
    );

    // Receiver / instruction memory / processor side
    modport slave (
        output rx_data, rx_valid, cpu_halting,
        input  rx_ready, imem_we, imem_addr, imem_data, cpu_reset, cpu_clk_en
    );
endinterface

// File: rtl/word_assembler.sv
// Pairs consecutive accepted bytes (high first) into 16-bit words.
// Latency: word_vld_o/word_dat_o are combinational in the low-byte accept cycle.
// Backpressure: none; caller only presents bytes it has already accepted.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [15:0] word_dat_o,
    output logic        phase_o
);
    logic [7:0] hi_q;
    logic       phase_q;

    // Hold the high byte and toggle the byte phase on every accepted byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q    <= 8'h00;
            phase_q <= 1'b0;
        end else if (clear_i) begin
            phase_q <= 1'b0;
        end else if (byte_vld_i) begin
            if (!phase_q) begin
                hi_q <= byte_dat_i;
            end
            phase_q <= ~phase_q;
        end
    end

    assign word_vld_o = byte_vld_i & phase_q & ~clear_i;
    assign word_dat_o = {hi_q, byte_dat_i};
    assign phase_o    = phase_q;
endmodule

// File: rtl/cpu_sequencer.sv
// Processor run control (run/pause/step/halt) and program loader from a byte stream.
// Latency: all outputs registered; control reacts one cycle after the input pulse, memory write one cycle after the low byte.
// Backpressure: rx_ready high only in the load states, at most one byte per cycle; memory write port never stalls.
module cpu_sequencer import simple_pkg::*; #(
    parameter int IMEM_AW = IMEM_AW_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             exec,
    input  logic             step,
    cpu_sequencer_if.master  bus,
    output logic [CNT_W-1:0] cycles,
    output logic [2:0]       state,
    output logic             load_err
);
    // Largest legal program length, in words
    localparam logic [16:0] MAX_LEN = 17'(2 ** IMEM_AW);

    logic [2:0]         state_q, state_d;
    logic               step_take;
    logic               rx_ready_q, rx_ready_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               cpu_clk_en_q, cpu_clk_en_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [15:0]        imem_data_q, imem_data_d;
    logic [15:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               load_err_q, load_err_d;

    logic               byte_acc;
    logic               word_vld;
    logic [15:0]        word_dat;
    logic               phase;
    logic               too_long;

    assign byte_acc = bus.rx_valid & rx_ready_q;
    assign too_long = ({1'b0, word_dat} > MAX_LEN);

    word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (state_q == ST_IDLE),
        .byte_vld_i (byte_acc),
        .byte_dat_i (bus.rx_data),
        .word_vld_o (word_vld),
        .word_dat_o (word_dat),
        .phase_o    (phase)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; IDLE priority is load > exec > step, halt beats exec
    always_comb begin
        state_d   = state_q;
        step_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_LEN_HI;
                end else if (exec) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d   = ST_PAUSE;
                    step_take = 1'b1;
                end
            end
            ST_LEN_HI: if (byte_acc && !phase) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (word_vld) begin
                    state_d = (word_dat == 16'd0 || too_long) ? ST_IDLE : ST_DAT_HI;
                end
            end
            ST_DAT_HI: if (byte_acc && !phase) state_d = ST_DAT_LO;
            ST_DAT_LO: begin
                if (word_vld) begin
                    state_d = (rem_q == 16'd1) ? ST_IDLE : ST_DAT_HI;
                end
            end
            ST_RUN: begin
                if (bus.cpu_halting) begin
                    state_d = ST_DONE;
                end else if (exec) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.cpu_halting) begin
                    state_d = ST_DONE;
                end else if (exec) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    step_take = 1'b1;
                end
            end
            ST_DONE: if (exec) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and loader datapath
    always_comb begin
        rx_ready_d   = is_load_state(state_d);
        cpu_reset_d  = (state_d == ST_IDLE) || is_load_state(state_d);
        cpu_clk_en_d = (state_d == ST_RUN) || step_take;

        imem_we_d    = (state_q == ST_DAT_LO) && word_vld;
        imem_data_d  = imem_we_d ? word_dat : imem_data_q;
        imem_addr_d  = imem_we_q ? imem_addr_q + IMEM_AW'(1) : imem_addr_q;

        rem_d        = rem_q;
        load_err_d   = load_err_q;
        cycles_d     = cycles_q;

        if (cpu_clk_en_q && !(&cycles_q)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end

        if (state_q == ST_IDLE && load) begin
            imem_addr_d = '0;
            cycles_d    = '0;
            load_err_d  = 1'b0;
        end

        if (state_q == ST_DONE && exec) begin
            cycles_d = '0;
        end

        if (state_q == ST_LEN_LO && word_vld) begin
            rem_d = word_dat;
            if (too_long) begin
                load_err_d = 1'b1;
            end
        end

        if (state_q == ST_DAT_LO && word_vld) begin
            rem_d = rem_q - 16'd1;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_data_q  <= NOP;
            rem_q        <= 16'd0;
            cycles_q     <= '0;
            load_err_q   <= 1'b0;
        end else begin
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            rem_q        <= rem_d;
            cycles_q     <= cycles_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.cpu_clk_en = cpu_clk_en_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_data  = imem_data_q;
    assign cycles         = cycles_q;
    assign state          = state_q;
    assign load_err       = load_err_q;
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Run-control and program-load sequencer for the 16-bit pipelined processor. It owns the processor's reset and clock-enable, and loads a program image from a byte stream (UART receiver side) into instruction memory through the instruction-memory write port. It also provides run, pause, single-step and halt detection, plus a run-cycle counter for the display. It sits between the board I/O (buttons, receiver) and the processor and its instruction memory.

## Interface
Parameters:
- IMEM_AW, 12, instruction memory address width (depth 2**IMEM_AW words)
- CNT_W, 32, run-cycle counter width

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- load  input  1  single-cycle pulse: start program load (accepted in IDLE only)
- exec  input  1  single-cycle pulse: run / pause toggle; acknowledge DONE
- step  input  1  single-cycle pulse: advance the processor by one clock
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  sequencer accepts byte (transfer on rx_valid & rx_ready)
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  IMEM_AW  write address
- imem_data  output  16  write data
- cpu_halting  input  1  processor halt indication
- cpu_reset  output  1  processor reset, active-high
- cpu_clk_en  output  1  processor clock enable
- cycles  output  CNT_W  clock-enabled cycles since last clear
- state  output  3  current state encoding, for display
- load_err  output  1  sticky: last load had an illegal length

## Operation
- States: IDLE=0, LEN_HI=1, LEN_LO=2, DAT_HI=3, DAT_LO=4, RUN=5, PAUSE=6, DONE=7.
- IDLE: cpu_reset=1, cpu_clk_en=0. Input priority when several inputs arrive in the same cycle: load > exec > step.
  - load → LEN_HI. Clears load_err, cycles and the word address.
  - exec → RUN. cpu_reset drops on entry.
  - step → PAUSE, with one enable cycle.
- Load path:
  - Length N is 16 bits, received high byte first. rx_ready=1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO.
  - N=0 → IDLE with no writes.
  - N>2**IMEM_AW → load_err=1 → IDLE with no writes.
  - Otherwise N words follow, each high byte then low byte. Each completed word is written at address 0,1,…,N-1.
  - After word N-1 is written → IDLE.
  - cpu_reset stays 1 throughout the load.
  - exec and step are ignored during LEN_*/DAT_*.
- RUN: cpu_reset=0, cpu_clk_en=1.
  - exec → PAUSE.
  - cpu_halting=1 → DONE. Halt takes priority over a simultaneous exec.
- PAUSE: cpu_clk_en=0, except one cycle per step pulse.
  - exec → RUN.
  - cpu_halting=1 → DONE.
- DONE: cpu_clk_en=0, cpu_reset=0 (processor state preserved for inspection).
  - exec → IDLE. cpu_reset reasserts and cycles clears.
  - load is ignored.
- cycles increments on every cycle with cpu_clk_en=1 and saturates at all-ones.
- Reset mid-load: the load is abandoned, already-written words stay in memory, the state returns to IDLE, and there is no error.

## Timing
- Reset values:
  - state=IDLE, cpu_reset=1, cpu_clk_en=0, rx_ready=0, imem_we=0, imem_addr=0, imem_data=0, cycles=0, load_err=0.
- All outputs are registered.
- Byte handshake: at most one byte is accepted per cycle. rx_ready is valid in the cycle after the state change.
- Word write: imem_we pulses high for one cycle, in the cycle after the low byte is accepted. imem_addr and imem_data are stable in that same cycle. imem_addr increments after the pulse.
- exec in IDLE at cycle t: cpu_reset=0 and cpu_clk_en=1 from cycle t+1.
- step accepted at cycle t: cpu_clk_en=1 during cycle t+1 only.
- cpu_halting seen at cycle t in RUN: cpu_clk_en=0 from cycle t+1, state=DONE at t+1.

## Structure
- Shared package simple_pkg holds:
  - the state encoding localparams,
  - the IMEM address width default,
  - the NOP encoding, so all blocks share a single definition.
- Sub-module word_assembler: combines high and low bytes into a 16-bit word, with a word-valid pulse and a byte-phase bit. It is reused by the length and data phases.

## Test plan
- Load N=3 (bytes 00 03 12 34 AB CD F0 0F) → writes 0x1234@0, 0xABCD@1, 0xF00F@2; imem_we pulses exactly 3 times; return to IDLE; load_err=0.
- Load N=0x1001 → load_err=1, no imem_we pulse, state=IDLE. A following legal load clears load_err.
- exec from IDLE, cpu_halting raised after 10 cycles → state=DONE, cycles=10, cpu_clk_en=0. exec → IDLE, cycles=0, cpu_reset=1.
- Step pulses ×3 from IDLE, spaced 5 cycles apart → exactly 3 single-cycle cpu_clk_en pulses, cycles=3, state=PAUSE.
- load, exec and step in the same cycle in IDLE → LEN_HI. In RUN, exec and cpu_halting in the same cycle → DONE.
- reset asserted after 3 bytes of a load, rx_valid held high → immediate IDLE with all outputs at reset values. After reset releases, no further bytes are accepted until a new load.
